aes_subbytes_engine: RTL and testbench

Sequential, parametrised SubBytes/InvSubBytes engine for the AES datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes LANES bytes per clock through LANES shared S-box lanes. A per-transaction mode bit selects the forward or the inverse S-box, so one instance serves both the encrypt and the decrypt round pipelines. It sits between AddRoundKey and ShiftRows (encrypt) or InvShiftRows and AddRoundKey (decrypt), and trades area against latency.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/aes_sbox_dual.sv | 15 +
 rtl/aes_subbytes_engine.sv | 130 +++++++++++++
 tb/tb_aes_subbytes_engine.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and constants for the SubBytes engine.
//   aes_state_t      : 16-byte AES state, byte 15 is the first AES byte
//   eng_state_t      : control states of the SubBytes engine
//   SBOX_FWD/INV     : forward and inverse S-box tables
//   beats_for_lanes  : number of substitution beats for a given lane count
package aes_pkg;

    typedef logic [15:0][7:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } eng_state_t;

    localparam logic [7:0] SBOX_FWD [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Guarded so an illegal LANES still elaborates far enough to hit the
    // explicit error in the top level instead of a divide-by-zero.
    function automatic int beats_for_lanes(input int lanes);
        return (lanes > 0) ? (16 / lanes) : 1;
    endfunction

endpackage

// File: rtl/aes_sbox_dual.sv
// Combined forward/inverse AES S-box lane, purely combinational.
//   addr    : byte to substitute
//   inverse : 0 = forward table, 1 = inverse table
//   result  : substituted byte
module aes_sbox_dual
    import aes_pkg::*;
(
    input  logic [7:0] addr,
    input  logic       inverse,
    output logic [7:0] result
);

    assign result = inverse ? SBOX_INV[addr] : SBOX_FWD[addr];

endmodule

// File: rtl/aes_subbytes_engine.sv
// Sequential SubBytes/InvSubBytes engine: substitutes LANES bytes per clock
// through LANES shared S-box lanes, byte 15 first.
//   clk, rst_n                     : clock, async active-low reset
//   in_valid/in_ready              : input handshake
//   in_inverse, in_state           : mode and state, sampled on accept
//   out_valid/out_ready            : output handshake, result held until taken
//   out_state, out_inverse         : registered result and its mode
//   busy                           : high while a transaction is in flight
//
// state   | meaning
// IDLE    | waiting for a state, in_ready high
// RUN     | one beat per cycle, LANES bytes substituted per beat
// DONE    | result presented; may reload directly into RUN on handshake
module aes_subbytes_engine
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_inverse,
    input  aes_state_t in_state,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t out_state,
    output logic       out_inverse,
    output logic       busy
);

    localparam int N  = beats_for_lanes(LANES);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("aes_subbytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    eng_state_t    state_q, state_d;
    logic [CW-1:0] beat_q;
    aes_state_t    work_q, work_nxt;
    logic          mode_q;
    aes_state_t    out_state_q;
    logic          out_inverse_q;

    logic          accept;
    logic          last_beat;
    logic [3:0]    base_idx;
    logic [7:0]    lane_addr [LANES];
    logic [7:0]    lane_res  [LANES];

    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_q == CW'(N - 1));
    // Highest byte index touched by the current beat; lanes walk downward.
    assign base_idx  = 4'd15 - 4'(beat_q * LANES);

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (last_beat) state_d = ST_DONE;
            end
            ST_DONE: begin
                // Consuming the result frees the engine on the same edge.
                in_ready = out_ready;
                if (out_ready) state_d = in_valid ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_addr[j] = work_q[base_idx - 4'(j)];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox_dual u_sbox (
            .addr    (lane_addr[g]),
            .inverse (mode_q),
            .result  (lane_res[g])
        );
    end

    always_comb begin
        work_nxt = work_q;
        for (int j = 0; j < LANES; j++) begin
            work_nxt[base_idx - 4'(j)] = lane_res[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            beat_q        <= '0;
            work_q        <= '0;
            mode_q        <= 1'b0;
            out_state_q   <= '0;
            out_inverse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                work_q <= in_state;
                mode_q <= in_inverse;
                beat_q <= '0;
            end else if (state_q == ST_RUN) begin
                work_q <= work_nxt;
                if (last_beat) begin
                    beat_q        <= '0;
                    out_state_q   <= work_nxt;
                    out_inverse_q <= mode_q;
                end else begin
                    beat_q <= beat_q + 1'b1;
                end
            end
        end
    end

    assign out_valid   = (state_q == ST_DONE);
    assign out_state   = out_state_q;
    assign out_inverse = out_inverse_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_subbytes_engine.sv
// Self-checking bench for aes_subbytes_engine. Five instances with
// LANES = 1, 2, 4, 8, 16 run against a cycle-level reference that derives
// the S-box from GF(2^8) arithmetic and tracks each instance's latency.
module tb_aes_subbytes_engine;
    import aes_pkg::*;

    localparam int NI = 5;

    localparam aes_state_t FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam aes_state_t FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid    [NI];
    logic       in_ready    [NI];
    logic       in_inverse  [NI];
    aes_state_t in_state    [NI];
    logic       out_valid   [NI];
    logic       out_ready   [NI];
    aes_state_t out_state   [NI];
    logic       out_inverse [NI];
    logic       busy        [NI];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] fwd_m [256];
    logic [7:0] inv_m [256];

    // Reference: cycles left until result, held result and its mode.
    int         m_cnt  [NI] = '{default: 0};
    logic       m_hold [NI] = '{default: 1'b0};
    aes_state_t m_res  [NI] = '{default: '0};
    logic       m_inv  [NI] = '{default: 1'b0};
    aes_state_t m_out  [NI] = '{default: '0};
    logic       m_oinv [NI] = '{default: 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_subbytes_engine #(.LANES(1 << g)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (in_valid[g]),
            .in_ready    (in_ready[g]),
            .in_inverse  (in_inverse[g]),
            .in_state    (in_state[g]),
            .out_valid   (out_valid[g]),
            .out_ready   (out_ready[g]),
            .out_state   (out_state[g]),
            .out_inverse (out_inverse[g]),
            .busy        (busy[g])
        );
    end

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] x, int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] invx;
        for (int x = 0; x < 256; x++) begin
            invx = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) invx = 8'(y);
            end
            fwd_m[x] = invx ^ rotl(invx, 1) ^ rotl(invx, 2) ^ rotl(invx, 3) ^ rotl(invx, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_m[fwd_m[x]] = 8'(x);
    endtask

    function automatic aes_state_t sub_bytes(aes_state_t s, logic inv);
        aes_state_t r;
        for (int b = 0; b < 16; b++) r[b] = inv ? inv_m[s[b]] : fwd_m[s[b]];
        return r;
    endfunction

    task automatic chk_b(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_s(string name, aes_state_t act, aes_state_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_i(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Reference model, stepped on the same edges as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                m_cnt[i]  <= 0;
                m_hold[i] <= 1'b0;
                m_out[i]  <= '0;
                m_oinv[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (m_cnt[i] != 0) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    if (m_cnt[i] == 1) begin
                        m_hold[i] <= 1'b1;
                        m_out[i]  <= m_res[i];
                        m_oinv[i] <= m_inv[i];
                    end
                end else begin
                    if (m_hold[i] && out_ready[i]) m_hold[i] <= 1'b0;
                    if (in_valid[i] && (!m_hold[i] || out_ready[i])) begin
                        m_cnt[i] <= 16 >> i;
                        m_res[i] <= sub_bytes(in_state[i], in_inverse[i]);
                        m_inv[i] <= in_inverse[i];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk_b($sformatf("cyc_in_ready[%0d]", i), in_ready[i],
                  (m_cnt[i] == 0) && (!m_hold[i] || out_ready[i]));
            chk_b($sformatf("cyc_out_valid[%0d]", i), out_valid[i], m_hold[i]);
            chk_b($sformatf("cyc_busy[%0d]", i), busy[i], (m_cnt[i] != 0) || m_hold[i]);
            if (m_hold[i]) begin
                chk_s($sformatf("cyc_out_state[%0d]", i), out_state[i], m_out[i]);
                chk_b($sformatf("cyc_out_inverse[%0d]", i), out_inverse[i], m_oinv[i]);
            end
        end
    end

    task automatic send(input int i, input aes_state_t s, input logic inv, output int c0);
        int t;
        t = 0;
        @(posedge clk);
        #1;
        in_valid[i]   = 1'b1;
        in_state[i]   = s;
        in_inverse[i] = inv;
        @(negedge clk);
        while (!in_ready[i] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready[i]) timeout($sformatf("send[%0d]", i));
        @(posedge clk);
        #1;
        c0 = cyc;
        in_valid[i] = 1'b0;
    endtask

    task automatic get(input int i, input int c0, output aes_state_t s, output logic inv, output int lat);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid[i] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid[i]) timeout($sformatf("get[%0d]", i));
        lat = cyc - c0;
        s   = out_state[i];
        inv = out_inverse[i];
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(string tag);
        for (int i = 0; i < NI; i++) begin
            chk_b($sformatf("%s_in_ready[%0d]", tag, i), in_ready[i], 1'b1);
            chk_b($sformatf("%s_out_valid[%0d]", tag, i), out_valid[i], 1'b0);
            chk_s($sformatf("%s_out_state[%0d]", tag, i), out_state[i], '0);
            chk_b($sformatf("%s_out_inverse[%0d]", tag, i), out_inverse[i], 1'b0);
            chk_b($sformatf("%s_busy[%0d]", tag, i), busy[i], 1'b0);
        end
    endtask

    initial begin
        aes_state_t r, a_res;
        logic       rinv;
        int         c0, lat;
        logic       ghost;

        build_tables();
        for (int i = 0; i < NI; i++) begin
            in_valid[i]   = 1'b0;
            in_inverse[i] = 1'b0;
            in_state[i]   = '0;
            out_ready[i]  = 1'b1;
        end

        // Pin the reference against published values.
        chk_s("model_sbox_00", {120'h0, fwd_m[8'h00]}, {120'h0, 8'h63});
        chk_s("model_inv_ed", {120'h0, inv_m[8'hed]}, {120'h0, 8'h53});
        chk_s("model_fips_fwd", sub_bytes(FIPS_IN, 1'b0), FIPS_OUT);
        chk_s("model_fips_inv", sub_bytes(FIPS_OUT, 1'b1), FIPS_IN);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // All-zero state, forward, LANES=4.
        send(2, '0, 1'b0, c0);
        get(2, c0, r, rinv, lat);
        chk_s("zero_fwd_state", r, {16{8'h63}});
        chk_i("zero_fwd_latency", lat, 4);

        // FIPS-197 vector through every lane count.
        for (int i = 0; i < NI; i++) begin
            send(i, FIPS_IN, 1'b0, c0);
            get(i, c0, r, rinv, lat);
            chk_s($sformatf("fips_fwd_state[L%0d]", 1 << i), r, FIPS_OUT);
            chk_b($sformatf("fips_fwd_mode[L%0d]", 1 << i), rinv, 1'b0);
            chk_i($sformatf("fips_fwd_latency[L%0d]", 1 << i), lat, 16 >> i);
        end

        // Inverse round trip and spot check.
        send(2, FIPS_OUT, 1'b1, c0);
        get(2, c0, r, rinv, lat);
        chk_s("inv_roundtrip_state", r, FIPS_IN);
        chk_b("inv_roundtrip_mode", rinv, 1'b1);
        send(3, {16{8'hed}}, 1'b1, c0);
        get(3, c0, r, rinv, lat);
        chk_s("inv_spot_ed", r, {16{8'h53}});

        // Backpressure then back-to-back reload on LANES=4.
        out_ready[2] = 1'b0;
        send(2, 128'h00112233445566778899aabbccddeeff, 1'b0, c0);
        get(2, c0, a_res, rinv, lat);
        chk_s("bp_result", a_res, sub_bytes(128'h00112233445566778899aabbccddeeff, 1'b0));
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk_s("bp_hold_state", out_state[2], a_res);
            chk_b("bp_hold_valid", out_valid[2], 1'b1);
            chk_b("bp_hold_in_ready", in_ready[2], 1'b0);
        end
        @(posedge clk);
        #1;
        in_valid[2]   = 1'b1;
        in_state[2]   = FIPS_OUT;
        in_inverse[2] = 1'b1;
        out_ready[2]  = 1'b1;
        @(negedge clk);
        chk_b("b2b_in_ready", in_ready[2], 1'b1);
        @(posedge clk);
        #1;
        c0 = cyc;
        in_valid[2] = 1'b0;
        @(negedge clk);
        chk_b("b2b_no_bubble_busy", busy[2], 1'b1);
        chk_b("b2b_consumed_valid", out_valid[2], 1'b0);
        get(2, c0, r, rinv, lat);
        chk_s("b2b_state", r, FIPS_IN);
        chk_i("b2b_latency", lat, 4);

        // Mode toggling during RUN must not disturb the latched mode.
        send(0, FIPS_IN, 1'b0, c0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            in_inverse[0] = ~in_inverse[0];
        end
        get(0, c0, r, rinv, lat);
        chk_s("mode_iso_fwd_state", r, FIPS_OUT);
        chk_b("mode_iso_fwd_mode", rinv, 1'b0);
        send(2, FIPS_OUT, 1'b1, c0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            in_inverse[2] = ~in_inverse[2];
        end
        get(2, c0, r, rinv, lat);
        chk_s("mode_iso_inv_state", r, FIPS_IN);
        chk_b("mode_iso_inv_mode", rinv, 1'b1);
        in_inverse[0] = 1'b0;
        in_inverse[2] = 1'b0;

        // Asynchronous reset during beat 7 of a LANES=1 transaction.
        send(0, FIPS_IN, 1'b0, c0);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        ghost = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid[0]) ghost = 1'b1;
        end
        chk_b("midrun_no_ghost_valid", ghost, 1'b0);
        send(0, FIPS_OUT, 1'b1, c0);
        get(0, c0, r, rinv, lat);
        chk_s("post_reset_state", r, FIPS_IN);
        chk_b("post_reset_mode", rinv, 1'b1);
        chk_i("post_reset_latency", lat, 16);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
